// File: rtl/rv_pkg.sv
// Shared definitions for the fetch path: opcodes, fetch FSM encoding, reset PC and NOP word.
package rv_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_REQ   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_VALID = 2'b10,
        ST_HALT  = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/pc_next_gen.sv
// Next-fetch address: sequential PC+4 or decoder redirect, plus alignment check on redirects.
module pc_next_gen
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);

    // Addition wraps naturally at XLEN bits, so the top word rolls over to zero.
    assign pc_plus4 = pc + {{(XLEN-3){1'b0}}, 3'd4};
    assign next_pc  = pc_src ? pc_target : pc_plus4;
    assign misalign = pc_src & (|pc_target[1:0]);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding req/gnt/rvalid transaction, valid/ready to decode,
// branch redirect on consume, sticky halt on a misaligned redirect target.
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            IMemReq,
    output logic [XLEN-1:0] IMemAddr,
    input  logic            IMemGnt,
    input  logic            IMemRValid,
    input  logic [31:0]     IMemRData,
    output logic [31:0]     Instr,
    output logic [6:0]      Opcode,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            InstrValid,
    input  logic            InstrReady,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            FetchMisalign
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            imem_req_q, imem_req_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] next_pc;
    logic            redirect_misalign;

    pc_next_gen #(.XLEN(XLEN)) u_pc_next_gen (
        .pc        (pc_q),
        .pc_src    (PCSrc),
        .pc_target (PCTarget),
        .pc_plus4  (PCPlus4),
        .next_pc   (next_pc),
        .misalign  (redirect_misalign)
    );

    // The request flop comes out of reset low, so the first REQ cycle after release raises it;
    // a grant only counts once the request is actually visible on the bus.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        imem_req_d    = imem_req_q;
        misalign_d    = misalign_q;
        case (state_q)
            ST_REQ: begin
                if (imem_req_q && IMemGnt) begin
                    imem_req_d = 1'b0;
                    state_d    = ST_WAIT;
                end else begin
                    imem_req_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (IMemRValid) begin
                    instr_d       = IMemRData;
                    pc_d          = fetch_pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = ST_VALID;
                end
            end
            ST_VALID: begin
                if (InstrReady) begin
                    instr_valid_d = 1'b0;
                    if (redirect_misalign) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        fetch_pc_d = next_pc;
                        imem_req_d = 1'b1;
                        state_d    = ST_REQ;
                    end
                end
            end
            default: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_REQ;
            fetch_pc_q    <= RESET_PC;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            misalign_q    <= misalign_d;
        end
    end

    assign IMemReq       = imem_req_q;
    assign IMemAddr      = fetch_pc_q;
    assign Instr         = instr_q;
    assign Opcode        = instr_q[6:0];
    assign PC            = pc_q;
    assign InstrValid    = instr_valid_q;
    assign FetchMisalign = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, delayed grant, redirects, stall,
// misaligned halt and reset in the middle of a transaction.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemGnt;
    logic        IMemRValid;
    logic [31:0] IMemRData;
    logic [31:0] Instr;
    logic [6:0]  Opcode;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        InstrValid;
    logic        InstrReady;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        FetchMisalign;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    instr_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .IMemReq       (IMemReq),
        .IMemAddr      (IMemAddr),
        .IMemGnt       (IMemGnt),
        .IMemRValid    (IMemRValid),
        .IMemRData     (IMemRData),
        .Instr         (Instr),
        .Opcode        (Opcode),
        .PC            (PC),
        .PCPlus4       (PCPlus4),
        .InstrValid    (InstrValid),
        .InstrReady    (InstrReady),
        .PCSrc         (PCSrc),
        .PCTarget      (PCTarget),
        .FetchMisalign (FetchMisalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Serves one fetch: waits (bounded) for a request, holds off the grant for gnt_delay
    // cycles while checking the address stays put, then returns word one cycle after grant.
    task automatic serve_fetch(input int gnt_delay, input logic [31:0] word, input logic [31:0] exp_addr);
        int waited = 0;
        while (IMemReq !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("req_seen", 32'(IMemReq), 32'd1);
        for (int i = 0; i < gnt_delay; i++) begin
            check("addr_held", IMemAddr, exp_addr);
            check("req_held", 32'(IMemReq), 32'd1);
            @(negedge clk);
        end
        check("addr", IMemAddr, exp_addr);
        IMemGnt = 1'b1;
        @(negedge clk);
        IMemGnt = 1'b0;
        check("req_drop", 32'(IMemReq), 32'd0);
        check("valid_wait", 32'(InstrValid), 32'd0);
        IMemRValid = 1'b1;
        IMemRData  = word;
        @(negedge clk);
        IMemRValid = 1'b0;
        IMemRData  = 32'hDEAD_BEEF;
        check("valid", 32'(InstrValid), 32'd1);
        check("instr", Instr, word);
        check("pc", PC, exp_addr);
        check("pc_plus4", PCPlus4, exp_addr + 32'd4);
        check("opcode", 32'(Opcode), 32'(word[6:0]));
    endtask

    task automatic consume(input logic src, input logic [31:0] target);
        InstrReady = 1'b1;
        PCSrc      = src;
        PCTarget   = target;
        @(negedge clk);
        InstrReady = 1'b0;
        PCSrc      = 1'b0;
        PCTarget   = 32'h0;
        check("valid_drop", 32'(InstrValid), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        IMemGnt    = 1'b0;
        IMemRValid = 1'b0;
        IMemRData  = 32'h0;
        InstrReady = 1'b0;
        PCSrc      = 1'b0;
        PCTarget   = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_req", 32'(IMemReq), 32'd0);
        check("rst_valid", 32'(InstrValid), 32'd0);
        check("rst_pc", PC, 32'h0);
        check("rst_instr", Instr, 32'h0);
        check("rst_misalign", 32'(FetchMisalign), 32'd0);
        rst = 1'b1;

        $display("[TB] sequential fetch");
        serve_fetch(0, 32'h0000_0013, 32'h0);
        check("opc_nop", 32'(Opcode), 32'h13);
        consume(1'b0, 32'h0);
        serve_fetch(0, 32'h0000_2083, 32'h4);
        check("opc_load", 32'(Opcode), 32'h03);
        consume(1'b0, 32'h0);
        serve_fetch(0, 32'h0020_81B3, 32'h8);
        check("opc_rtype", 32'(Opcode), 32'h33);

        $display("[TB] redirects and delayed grant");
        consume(1'b1, 32'h40);
        check("redirect_addr", IMemAddr, 32'h40);
        serve_fetch(3, 32'h0000_0063, 32'h40);
        check("opc_branch", 32'(Opcode), 32'h63);
        consume(1'b0, 32'h40);
        check("seq_addr", IMemAddr, 32'h44);
        serve_fetch(2, 32'h0011_2023, 32'h44);
        check("opc_store", 32'(Opcode), 32'h23);
        consume(1'b1, 32'hFFFF_FFFC);
        serve_fetch(0, 32'h0000_0013, 32'hFFFF_FFFC);
        check("wrap_plus4", PCPlus4, 32'h0);
        consume(1'b0, 32'h0);
        serve_fetch(1, 32'h0011_2023, 32'h0);

        $display("[TB] stall in VALID");
        PCSrc    = 1'b1;
        PCTarget = 32'h42;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(InstrValid), 32'd1);
            check("stall_instr", Instr, 32'h0011_2023);
            check("stall_pc", PC, 32'h0);
            check("stall_req", 32'(IMemReq), 32'd0);
            check("stall_misalign", 32'(FetchMisalign), 32'd0);
        end

        $display("[TB] misaligned redirect");
        consume(1'b1, 32'h42);
        check("misalign_set", 32'(FetchMisalign), 32'd1);
        InstrReady = 1'b1;
        IMemGnt    = 1'b1;
        IMemRValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("halt_req", 32'(IMemReq), 32'd0);
            check("halt_valid", 32'(InstrValid), 32'd0);
            check("halt_misalign", 32'(FetchMisalign), 32'd1);
        end
        InstrReady = 1'b0;
        IMemGnt    = 1'b0;
        IMemRValid = 1'b0;

        $display("[TB] reset during WAIT");
        rst = 1'b0;
        @(negedge clk);
        check("rst2_misalign", 32'(FetchMisalign), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_req", 32'(IMemReq), 32'd1);
        IMemGnt = 1'b1;
        @(negedge clk);
        IMemGnt = 1'b0;
        check("rst2_in_wait", 32'(IMemReq), 32'd0);
        rst = 1'b0;
        #1;
        check("rst2_async_req", 32'(IMemReq), 32'd0);
        check("rst2_async_valid", 32'(InstrValid), 32'd0);
        @(negedge clk);
        rst        = 1'b1;
        IMemRValid = 1'b1;
        IMemRData  = 32'hCAFE_F00D;
        repeat (2) begin
            @(negedge clk);
            check("stray_valid", 32'(InstrValid), 32'd0);
            check("stray_addr", IMemAddr, 32'h0);
        end
        IMemRValid = 1'b0;
        serve_fetch(0, 32'h0000_0013, 32'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
